// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle between a controlling FSM and serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
`ifdef SUB_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             bout_r;
    logic             x, y, r, d, borrow_nxt, last;
`ifdef SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_r;
`endif

    // Single full-subtractor cell fed by the operand LSBs and the stored borrow
    always_comb begin
        x          = a_sh[0];
        y          = b_sh[0];
        r          = borrow;
        d          = x ^ y ^ r;
        borrow_nxt = (~x & y) | (~x & r) | (y & r);
        last       = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // DONE accepts a new start just like IDLE, allowing back-to-back operations
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            bout_r <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
`ifdef SUB_OVF_EN
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                    end
                end
                BUSY: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    diff_r <= {d, diff_r[WIDTH-1:1]};
                    borrow <= borrow_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout_r <= borrow_nxt;
`ifdef SUB_OVF_EN
                        // The final bit produced is the result sign
                        ovf_r  <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == BUSY);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
`ifdef SUB_OVF_EN
    assign bus.ovf  = ovf_r;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); define SUB_OVF_EN to also check ovf.
module tb_serial_subtractor;
    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t expq[$];
    exp_t e;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = expq.pop_front();
                checkOutput("diff", int'(bus.diff), int'(e.diff));
                checkOutput("bout", int'(bus.bout), int'(e.bout));
`ifdef SUB_OVF_EN
                checkOutput("ovf", int'(bus.ovf), int'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        int busyCnt;
        expq.push_back('{ed, eb, eo});
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat       = 0;
        busyCnt   = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
            if (bus.busy) busyCnt++;
            if (bus.done) lat = k;
        end
        checkOutput("latency", lat, 9);
        checkOutput("busy_cycles", busyCnt, 8);
    endtask

    initial begin
        int dones;
        int lat;
        int t1;
        int t2;
        int gap;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_diff", int'(bus.diff), 0);
        checkOutput("reset_bout", int'(bus.bout), 0);
`ifdef SUB_OVF_EN
        checkOutput("reset_ovf", int'(bus.ovf), 0);
`endif

        applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);

        // A start pulse during BUSY must be ignored
        expq.push_back('{8'h0F, 1'b0, 1'b0});
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        dones     = 0;
        lat       = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end
            if (k == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = k;
            end
        end
        checkOutput("ignored_start_dones", dones, 1);
        checkOutput("ignored_start_latency", lat, 9);

        // Back-to-back with start held high
        bus.start = 1'b1;
        bus.a     = 8'h20;
        bus.b     = 8'h10;
        expq.push_back('{8'h10, 1'b0, 1'b0});
        dones = 0;
        t1    = 0;
        t2    = 0;
        gap   = 0;
        for (int k = 1; k <= 30 && dones < 2; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    t1    = k;
                    bus.a = 8'h01;
                    bus.b = 8'h02;
                    expq.push_back('{8'hFF, 1'b1, 1'b0});
                end else begin
                    t2        = k;
                    bus.start = 1'b0;
                end
            end else if (dones == 1 && !bus.busy) begin
                gap++;
            end
        end
        checkOutput("b2b_dones", dones, 2);
        checkOutput("b2b_spacing", t2 - t1, 9);
        checkOutput("b2b_busy_gap", gap, 0);
        @(negedge clk);

        // Reset mid-operation discards the partial result
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", int'(bus.busy), 0);
        checkOutput("midreset_done", int'(bus.done), 0);
        checkOutput("midreset_diff", int'(bus.diff), 0);
        checkOutput("midreset_bout", int'(bus.bout), 0);
        reset = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("midreset_no_done", dones, 0);
        applyStimulus(8'h09, 8'h04, 8'h05, 1'b0, 1'b0);
        @(negedge clk);

        // Signed-overflow vectors (ovf checked only when the feature is built)
        applyStimulus(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
